// File: rtl/hex_word_emitter_if.sv
// Handshake bundle between a word source, the hex emitter and the UART byte transmitter.
// The slave view is the emitter; the master view drives words in and accepts bytes out.
interface hex_word_emitter_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] in_word;
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            out_byte;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;

    modport slave (
        input  in_word,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_byte,
        output out_valid,
        output busy
    );

    modport master (
        output in_word,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_byte,
        input  out_valid,
        input  busy
    );
endinterface

// File: rtl/hex_word_emitter.sv
// Streams one word as lowercase ASCII hex, most significant nibble first,
// with an optional CR LF trailer.
module hex_word_emitter #(
    parameter int WORD_WIDTH = 16,
    parameter bit EMIT_CRLF  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    hex_word_emitter_if.slave bus
);
    localparam int NDIG  = WORD_WIDTH / 4;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DIGIT,
        CR,
        LF
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WORD_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic [3:0]            w_nibble;
    logic [7:0]            w_byte;
    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_accept;
    logic                  w_xfer;

    // Outputs depend only on registered state, so there is no in->out combinational path.
    assign w_in_ready  = (r_state == IDLE) && !reset;
    assign w_out_valid = (r_state != IDLE);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_xfer      = w_out_valid && bus.out_ready;
    assign w_nibble    = r_shift[WORD_WIDTH-1 -: 4];

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_out_valid;
    assign bus.out_byte  = w_byte;

    always_comb begin
        w_state_nxt = r_state;
        w_byte      = 8'h00;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = DIGIT;
                end
            end
            DIGIT: begin
                if (w_nibble < 4'd10) begin
                    w_byte = 8'h30 + {4'h0, w_nibble};
                end else begin
                    w_byte = 8'h57 + {4'h0, w_nibble};
                end
                if (w_xfer && (r_cnt == '0)) begin
                    w_state_nxt = EMIT_CRLF ? CR : IDLE;
                end
            end
            CR: begin
                w_byte = 8'h0d;
                if (w_xfer) begin
                    w_state_nxt = LF;
                end
            end
            LF: begin
                w_byte = 8'h0a;
                if (w_xfer) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_shift <= bus.in_word;
                r_cnt   <= CNT_W'(NDIG - 1);
            end else if (w_xfer && (r_state == DIGIT)) begin
                r_shift <= r_shift << 4;
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_hex_word_emitter.sv
// Directed bench for hex_word_emitter: default 16-bit/CRLF build plus 8-bit no-CRLF
// and single-digit builds.
module tb_hex_word_emitter;
    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    hex_word_emitter_if #(.WORD_WIDTH(16)) bus16 ();
    hex_word_emitter_if #(.WORD_WIDTH(8))  bus8 ();
    hex_word_emitter_if #(.WORD_WIDTH(4))  bus4 ();

    hex_word_emitter #(.WORD_WIDTH(16), .EMIT_CRLF(1'b1)) dut16 (
        .clk(clk), .reset(reset), .bus(bus16)
    );
    hex_word_emitter #(.WORD_WIDTH(8), .EMIT_CRLF(1'b0)) dut8 (
        .clk(clk), .reset(reset), .bus(bus8)
    );
    hex_word_emitter #(.WORD_WIDTH(4), .EMIT_CRLF(1'b1)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4)
    );

    typedef struct {
        logic [15:0] word;
        logic [47:0] bytes;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_byte(input string name, input logic [7:0] exp);
        check({name, ".valid"}, {15'h0, bus16.out_valid}, 16'h1);
        check({name, ".busy"}, {15'h0, bus16.busy}, 16'h1);
        check({name, ".byte"}, {8'h0, bus16.out_byte}, {8'h0, exp});
    endtask

    task automatic chk_idle16(input string name);
        check({name, ".valid"}, {15'h0, bus16.out_valid}, 16'h0);
        check({name, ".busy"}, {15'h0, bus16.busy}, 16'h0);
        check({name, ".in_ready"}, {15'h0, bus16.in_ready}, 16'h1);
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic accept_word(input logic [15:0] w);
        bus16.in_word  = w;
        bus16.in_valid = 1'b1;
        for (int i = 0; i < 20 && bus16.in_ready !== 1'b1; i++) @(negedge clk);
        check("accept.in_ready", {15'h0, bus16.in_ready}, 16'h1);
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
    endtask

    // One byte per cycle with out_ready held high, then idle the following cycle.
    task automatic expect_seq(input string name, input logic [47:0] bytes);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk_byte(name, bytes[47-8*k -: 8]);
        end
        @(negedge clk);
        chk_idle16({name, ".end"});
    endtask

    initial begin
        vecs[0] = '{16'h12ab, 48'h3132_6162_0d0a};
        vecs[1] = '{16'h0000, 48'h3030_3030_0d0a};
        vecs[2] = '{16'hffff, 48'h6666_6666_0d0a};
        vecs[3] = '{16'h9a0f, 48'h3961_3066_0d0a};
        vecs[4] = '{16'hc7e3, 48'h6337_6533_0d0a};
        vecs[5] = '{16'h8d5b, 48'h3864_3562_0d0a};

        reset          = 1'b1;
        bus16.in_word  = '0; bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
        bus8.in_word   = '0; bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b1;
        bus4.in_word   = '0; bus4.in_valid  = 1'b0; bus4.out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.valid", {15'h0, bus16.out_valid}, 16'h0);
        check("rst.byte", {8'h0, bus16.out_byte}, 16'h0);
        check("rst.busy", {15'h0, bus16.busy}, 16'h0);
        check("rst.in_ready", {15'h0, bus16.in_ready}, 16'h0);
        check("rst8.valid", {15'h0, bus8.out_valid}, 16'h0);
        reset = 1'b0;
        @(negedge clk);
        chk_idle16("post_rst");

        // Back-to-back words from the table, including all-zero and all-f.
        for (int v = 0; v < 6; v++) begin
            accept_word(vecs[v].word);
            expect_seq($sformatf("vec%0d", v), vecs[v].bytes);
        end

        // Backpressure for three edges while 'a' (0x61) is presented.
        accept_word(16'h12ab);
        @(negedge clk); chk_byte("bp0", 8'h31);
        @(negedge clk); chk_byte("bp1", 8'h32);
        @(negedge clk); chk_byte("bp2", 8'h61);
        bus16.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_byte("bp_hold", 8'h61);
        end
        bus16.out_ready = 1'b1;
        @(negedge clk); chk_byte("bp3", 8'h62);
        @(negedge clk); chk_byte("bp4", 8'h0d);
        @(negedge clk); chk_byte("bp5", 8'h0a);
        @(negedge clk); chk_idle16("bp_end");

        // in_valid asserted with 0xdead while busy must be ignored.
        accept_word(16'h5678);
        bus16.in_word  = 16'hdead;
        bus16.in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk_byte("ign", (k < 4) ? 8'h35 + 8'(k) : ((k == 4) ? 8'h0d : 8'h0a));
            check("ign.in_ready", {15'h0, bus16.in_ready}, 16'h0);
        end
        bus16.in_word = 16'hbeef;
        @(negedge clk);
        chk_idle16("ign_end");
        accept_word(16'hbeef);
        expect_seq("beef", 48'h6265_6566_0d0a);

        // Reset after the second digit aborts; the next word prints in full.
        accept_word(16'h1234);
        @(negedge clk); chk_byte("mr0", 8'h31);
        @(negedge clk); chk_byte("mr1", 8'h32);
        reset = 1'b1;
        @(negedge clk);
        check("mr.valid", {15'h0, bus16.out_valid}, 16'h0);
        check("mr.busy", {15'h0, bus16.busy}, 16'h0);
        check("mr.in_ready", {15'h0, bus16.in_ready}, 16'h0);
        reset = 1'b0;
        accept_word(16'h00ff);
        expect_seq("after_rst", 48'h3030_6666_0d0a);

        // 8-bit word, digits only.
        check("w8.in_ready", {15'h0, bus8.in_ready}, 16'h1);
        bus8.in_word  = 8'he9;
        bus8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        check("w8.b0.valid", {15'h0, bus8.out_valid}, 16'h1);
        check("w8.b0", {8'h0, bus8.out_byte}, 16'h0065);
        @(negedge clk);
        check("w8.b1.valid", {15'h0, bus8.out_valid}, 16'h1);
        check("w8.b1", {8'h0, bus8.out_byte}, 16'h0039);
        @(negedge clk);
        check("w8.end.valid", {15'h0, bus8.out_valid}, 16'h0);
        check("w8.end.in_ready", {15'h0, bus8.in_ready}, 16'h1);
        check("w8.end.busy", {15'h0, bus8.busy}, 16'h0);

        // Single-digit word with CR LF.
        bus4.in_word  = 4'hc;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        @(negedge clk);
        check("w4.b0", {7'h0, bus4.out_valid, bus4.out_byte}, 16'h0163);
        @(negedge clk);
        check("w4.b1", {7'h0, bus4.out_valid, bus4.out_byte}, 16'h010d);
        @(negedge clk);
        check("w4.b2", {7'h0, bus4.out_valid, bus4.out_byte}, 16'h010a);
        @(negedge clk);
        check("w4.end", {7'h0, bus4.out_valid, 7'h0, bus4.in_ready}, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
